// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - data-memory bus responder: local RAM plus I/O register page
//
// Answers the CPU data-port req/ack handshake. Each captured request is
// acknowledged exactly once, WAIT_STATES cycles later than the minimum.
//
// Ports:
//   clk_i   - CPU clock, rising edge
//   rst_ni  - asynchronous active-low reset
//   req_i   - request level, sampled only in IDLE
//   we_i    - 1 = write, 0 = read
//   adr_i   - word address (RAM below 0xFF00, I/O page at 0xFF00..0xFFFF)
//   dat_i   - write data
//   dat_o   - read data, valid in the ack cycle and held until the next read
//   ack_o   - one-cycle completion pulse
//   led_o   - LED register contents
//   err_o   - one-cycle pulse, with ack_o, on an unmapped I/O access
module dm_responder #(
    parameter int unsigned AW          = 10,
    parameter int unsigned WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [15:0] adr_i,
    input  logic [15:0] dat_i,
    output logic [15:0] dat_o,
    output logic        ack_o,
    output logic [7:0]  led_o,
    output logic        err_o
);

    localparam logic [3:0]  WS       = 4'(WAIT_STATES);
    localparam logic [15:0] IO_BASE  = 16'hFF00;
    localparam logic [15:0] ADR_LED  = 16'hFF00;
    localparam logic [15:0] ADR_CLO  = 16'hFF01;
    localparam logic [15:0] ADR_CHI  = 16'hFF02;
    localparam logic [15:0] ADR_SCR  = 16'hFF03;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_ACK    = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        we_q, we_d;
    logic [15:0] adr_q, adr_d;
    logic [15:0] wdat_q, wdat_d;

    logic [7:0]  led_q, led_d;
    logic [15:0] scr_q, scr_d;
    logic [31:0] cyc_q, cyc_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] io_dat_q, io_dat_d;
    logic        rsel_q, rsel_d;
    logic        err_q, err_d;

    logic [15:0] mem_q [2**AW];
    logic [15:0] ram_rdata_q;

    logic        access;
    logic        is_ram;
    logic        ram_we;
    logic        ram_re;

    // ------------------------------------------------------------------
    // Handshake state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    adr_d   = adr_i;
                    wdat_d  = dat_i;
                    wcnt_d  = WS;
                    state_d = (WS != 4'd0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                // The counter starts at WAIT_STATES, so leaving on 1 spends
                // exactly WAIT_STATES cycles here.
                wcnt_d = wcnt_q - 4'd1;
                if (wcnt_q <= 4'd1) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: state_d = S_ACK;
            S_ACK:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Access decode (captured values only)
    // ------------------------------------------------------------------
    assign access = (state_q == S_ACCESS);
    assign is_ram = (adr_q < IO_BASE);
    assign ram_we = access && is_ram && we_q;
    assign ram_re = access && is_ram && !we_q;

    // ------------------------------------------------------------------
    // RAM: synchronous read straight into the read-data register, so the
    // value is on dat_o throughout the ACK cycle. Not reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            mem_q[adr_q[AW-1:0]] <= wdat_q;
        end
        if (ram_re) begin
            ram_rdata_q <= mem_q[adr_q[AW-1:0]];
        end
    end

    // ------------------------------------------------------------------
    // I/O page, cycle counter and read-data selection
    // ------------------------------------------------------------------
    always_comb begin
        led_d    = led_q;
        scr_d    = scr_q;
        shadow_d = shadow_q;
        io_dat_d = io_dat_q;
        rsel_d   = rsel_q;
        err_d    = 1'b0;
        cyc_d    = cyc_q + 32'd1;
        if (access) begin
            if (is_ram) begin
                if (!we_q) begin
                    rsel_d = 1'b1;
                end
            end else begin
                if (!we_q) begin
                    rsel_d = 1'b0;
                end
                case (adr_q)
                    ADR_LED: begin
                        if (we_q) led_d    = wdat_q[7:0];
                        else      io_dat_d = {8'h00, led_q};
                    end
                    ADR_CLO: begin
                        // Clear wins over the increment in the same cycle.
                        if (we_q) begin
                            cyc_d = '0;
                        end else begin
                            io_dat_d = cyc_q[15:0];
                            shadow_d = cyc_q[31:16];
                        end
                    end
                    ADR_CHI: begin
                        if (!we_q) io_dat_d = shadow_q;
                    end
                    ADR_SCR: begin
                        if (we_q) scr_d    = wdat_q;
                        else      io_dat_d = scr_q;
                    end
                    default: begin
                        err_d = 1'b1;
                        if (!we_q) io_dat_d = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            led_q    <= '0;
            scr_q    <= '0;
            cyc_q    <= '0;
            shadow_q <= '0;
            io_dat_q <= '0;
            rsel_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            led_q    <= led_d;
            scr_q    <= scr_d;
            cyc_q    <= cyc_d;
            shadow_q <= shadow_d;
            io_dat_q <= io_dat_d;
            rsel_q   <= rsel_d;
            err_q    <= err_d;
        end
    end

    // rsel_q resets to the I/O path, whose register resets to zero, so
    // dat_o is zero out of reset even though the RAM register is not reset.
    assign dat_o = rsel_q ? ram_rdata_q : io_dat_q;
    assign ack_o = (state_q == S_ACK);
    assign err_o = err_q;
    assign led_o = led_q;

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - scoreboard bench for dm_responder
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we;
    logic [15:0] adr, dat;
    logic [15:0] dat_o;
    logic        ack, err;
    logic [7:0]  led;

    logic        req3, we3;
    logic [15:0] adr3, dat3i;
    logic [15:0] dat3o;
    logic        ack3, err3;
    logic [7:0]  led3;

    always #5 clk = ~clk;

    dm_responder #(.AW(10), .WAIT_STATES(0), .INIT_FILE("")) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .req_i (req),
        .we_i  (we),
        .adr_i (adr),
        .dat_i (dat),
        .dat_o (dat_o),
        .ack_o (ack),
        .led_o (led),
        .err_o (err)
    );

    dm_responder #(.AW(10), .WAIT_STATES(3), .INIT_FILE("")) dut3 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .req_i (req3),
        .we_i  (we3),
        .adr_i (adr3),
        .dat_i (dat3i),
        .dat_o (dat3o),
        .ack_o (ack3),
        .led_o (led3),
        .err_o (err3)
    );

    longint edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Reference model: memory map, registers and a cycle counter expressed
    // as "edges since the counter last restarted".
    typedef struct {
        longint      edge_n;
        logic [15:0] dat;
        bit          dchk;
        logic        err;
        logic [7:0]  led;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mem_m [int];
    logic [7:0]  led_m;
    logic [15:0] scr_m, shadow_m, dat_m;
    bit          dat_known;
    longint      base_b;

    function automatic void model(logic w, logic [15:0] a, logic [15:0] d, longint s);
        longint      acc;
        logic [31:0] cv;
        logic [15:0] rd;
        bit          known;
        logic        e;
        int          k;
        exp_t        x;
        acc   = s + 1;
        cv    = 32'(acc - base_b);
        rd    = 16'h0000;
        known = 1'b1;
        e     = 1'b0;
        k     = int'(a[9:0]);
        if (a < 16'hFF00) begin
            if (w) mem_m[k] = d;
            else if (mem_m.exists(k)) rd = mem_m[k];
            else known = 1'b0;
        end else if (a == 16'hFF00) begin
            if (w) led_m = d[7:0];
            else rd = {8'h00, led_m};
        end else if (a == 16'hFF01) begin
            if (w) base_b = acc + 1;
            else begin
                rd       = cv[15:0];
                shadow_m = cv[31:16];
            end
        end else if (a == 16'hFF02) begin
            rd = shadow_m;
        end else if (a == 16'hFF03) begin
            if (w) scr_m = d;
            else rd = scr_m;
        end else begin
            e = 1'b1;
        end
        if (!w) begin
            dat_m     = rd;
            dat_known = known;
        end
        x.edge_n = acc;
        x.dat    = dat_m;
        x.dchk   = dat_known;
        x.err    = e;
        x.led    = led_m;
        sb.push_back(x);
    endfunction

    // Monitor: every ack must match the head of the scoreboard, in time.
    exp_t mx;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (ack === 1'b1 || (sb.size() > 0 && sb[0].edge_n == edge_cnt)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    mx = sb.pop_front();
                    chk("ack", 32'(ack), 32'd1);
                    chk("ack_cycle", 32'(edge_cnt), 32'(mx.edge_n));
                    if (mx.dchk) chk("dat_o", 32'(dat_o), 32'(mx.dat));
                    chk("err_o", 32'(err), 32'(mx.err));
                    chk("led_o", 32'(led), 32'(mx.led));
                end
            end else begin
                chk("err_idle", 32'(err), 32'd0);
            end
        end
    end

    // Called at a negedge while the DUT is idle; returns at the negedge of
    // the next IDLE cycle. Bus fields are scrambled after capture.
    task automatic issue(logic w, logic [15:0] a, logic [15:0] d, bit keep);
        longint s;
        req = 1'b1;
        we  = w;
        adr = a;
        dat = d;
        s   = edge_cnt + 1;
        model(w, a, d, s);
        @(negedge clk);
        if (!keep) req = 1'b0;
        we  = 1'($urandom);
        adr = 16'($urandom);
        dat = 16'($urandom);
        while (edge_cnt < s + 2) @(negedge clk);
    endtask

    task automatic w3_txn(logic w, logic [15:0] a, logic [15:0] d, bit check_rd, logic [15:0] exp_rd);
        req3  = 1'b1;
        we3   = w;
        adr3  = a;
        dat3i = d;
        chk("w3_ack_c0", 32'(ack3), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req3 = 1'b0;
                adr3 = 16'hFFFF;
            end
            chk($sformatf("w3_ack_c%0d", k), 32'(ack3), (k == 5) ? 32'd1 : 32'd0);
            if (k == 5 && check_rd) chk("w3_dat", 32'(dat3o), 32'(exp_rd));
            if (k == 5) chk("w3_err", 32'(err3), 32'd0);
        end
    endtask

    logic [15:0] ra;
    logic        rw;
    bit          rk;
    int          rr;

    initial begin
        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; adr = '0; dat = '0;
        req3 = 1'b0; we3 = 1'b0; adr3 = '0; dat3i = '0;
        led_m = '0; scr_m = '0; shadow_m = '0; dat_m = '0; dat_known = 1'b1;
        base_b = 0;
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_dat", 32'(dat_o), 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        rst_n  = 1'b1;
        base_b = edge_cnt + 1;
        @(negedge clk);

        issue(1'b1, 16'h0010, 16'hBEEF, 1'b0);
        issue(1'b0, 16'h0010, 16'h0000, 1'b0);
        issue(1'b1, 16'h0400, 16'h1234, 1'b0);
        issue(1'b0, 16'h0000, 16'h0000, 1'b0);
        issue(1'b1, 16'hFF00, 16'h00A5, 1'b0);
        chk("led_a5", 32'(led), 32'h0000_00A5);
        issue(1'b0, 16'hFF00, 16'h0000, 1'b0);
        issue(1'b1, 16'hFF03, 16'h55AA, 1'b0);
        issue(1'b0, 16'hFF03, 16'h0000, 1'b0);
        issue(1'b0, 16'hFF10, 16'h0000, 1'b0);
        issue(1'b1, 16'hFF10, 16'h9999, 1'b0);
        issue(1'b0, 16'hFF02, 16'h0000, 1'b0);

        // Counter clear, then a read that must be small.
        issue(1'b1, 16'hFF01, 16'h0000, 1'b0);
        issue(1'b0, 16'hFF01, 16'h0000, 1'b0);
        // Run up to just below the 16-bit rollover, then LO then HI.
        while (edge_cnt < base_b + 65532) @(negedge clk);
        issue(1'b0, 16'hFF01, 16'h0000, 1'b0);
        issue(1'b0, 16'hFF02, 16'h0000, 1'b0);
        issue(1'b0, 16'hFF01, 16'h0000, 1'b0);
        issue(1'b0, 16'hFF02, 16'h0000, 1'b0);

        // Back-to-back with req held high.
        issue(1'b1, 16'h0020, 16'h1111, 1'b1);
        issue(1'b1, 16'h0021, 16'h2222, 1'b1);
        issue(1'b0, 16'h0020, 16'h0000, 1'b1);
        issue(1'b0, 16'h0021, 16'h0000, 1'b0);

        // Wait-state instance: exact ack cycle.
        w3_txn(1'b1, 16'h0010, 16'hCAFE, 1'b0, 16'h0000);
        w3_txn(1'b0, 16'h0010, 16'h0000, 1'b1, 16'hCAFE);

        // Reset in cycle 1 of a pending LED write.
        issue(1'b1, 16'hFF00, 16'h005A, 1'b0);
        issue(1'b0, 16'hFF03, 16'h0000, 1'b0);
        req = 1'b1; we = 1'b1; adr = 16'hFF00; dat = 16'h00FF;
        @(negedge clk);
        req   = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_ack", 32'(ack), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_dat", 32'(dat_o), 32'd0);
        chk("midrst_led", 32'(led), 32'd0);
        repeat (3) @(negedge clk);
        chk("midrst_ack_held", 32'(ack), 32'd0);
        rst_n = 1'b1;
        base_b = edge_cnt + 1;
        led_m = '0; scr_m = '0; shadow_m = '0; dat_m = '0; dat_known = 1'b1;
        @(negedge clk);
        issue(1'b0, 16'hFF03, 16'h0000, 1'b0);
        issue(1'b0, 16'hFF02, 16'h0000, 1'b0);
        issue(1'b0, 16'h0000, 16'h0000, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            rr = $urandom_range(0, 99);
            rw = 1'($urandom);
            rk = ($urandom_range(0, 3) == 0);
            if (rr < 55)
                ra = {6'($urandom_range(0, 62)), 10'($urandom_range(0, 15))};
            else if (rr < 85)
                ra = 16'hFF00 + 16'($urandom_range(0, 3));
            else
                ra = 16'hFF04 + 16'($urandom_range(0, 251));
            issue(rw, ra, 16'($urandom), rk);
        end
        issue(1'b0, 16'hFF03, 16'h0000, 1'b0);

        repeat (10) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
